cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. Sits beside the MEM stage, owns SR/Cause/EPC/PRId, arbitrates hardware interrupts against synchronous exceptions, and drives the request and return-address inputs consumed by next-PC selection (`int_req` → handler vector 0x0000_4180, `epc_out` → eret target). Accessed by mfc0/mtc0 at MEM.

---
 rtl/cp0_exc_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller for the 5-stage pipeline.
//
// Sits beside the MEM stage. Owns SR(12), Cause(13), EPC(14) and PRId(15),
// arbitrates level-sensitive hardware interrupts against synchronous exceptions
// and drives next-PC selection: int_req redirects to the handler vector,
// epc_out is the eret target.
//
// Optional feature: define CP0_TIMER_EN to add Count(9) and Compare(11) with a
// sticky compare-match flag ORed into Cause.IP[15]. When CP0_TIMER_EN is not
// defined, addresses 9 and 11 read 0 and ignore writes.
//
// Ports:
//   clk        pipeline clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   addr       CP0 register number for mfc0/mtc0
//   we         mtc0 write enable
//   din        mtc0 write data
//   dout       mfc0 read data, combinational, pre-edge register contents
//   pc         PC of the MEM-stage instruction
//   bd         MEM instruction is in a branch delay slot
//   exc_valid  MEM instruction raised a synchronous exception
//   exc_code   ExcCode of that exception
//   eret       MEM instruction is eret
//   hwint      level-sensitive external interrupt lines
//   int_req    take exception/interrupt this cycle (flush + redirect)
//   epc_out    eret return address, with same-cycle mtc0 EPC bypass

module cp0_exc_ctrl #(
   parameter logic [31:0] PRID = 32'h4255_4141
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [31:0] pc,
   input  logic        bd,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic        eret,
   input  logic [5:0]  hwint,
   output logic        int_req,
   output logic [31:0] epc_out
);

   localparam logic [4:0] AddrCount   = 5'd9;
   localparam logic [4:0] AddrCompare = 5'd11;
   localparam logic [4:0] AddrSr      = 5'd12;
   localparam logic [4:0] AddrCause   = 5'd13;
   localparam logic [4:0] AddrEpc     = 5'd14;
   localparam logic [4:0] AddrPrid    = 5'd15;

   // SR fields
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;

   // Cause fields
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;

   // EPC, low two bits always zero
   logic [31:0] epc_q, epc_d;

   // Decoded request terms
   logic [5:0]  ip_next;
   logic        irq;
   logic        exc;
   logic        wr_en;
   logic        wr_sr;
   logic        wr_epc;
   logic [31:0] pc_target;

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        timer_flag_q, timer_flag_d;
   logic        wr_count;
   logic        wr_compare;
`endif

   // -----------------------------------------------------------------------
   // Pending interrupt lines for this cycle
   // -----------------------------------------------------------------------
   always_comb begin
`ifdef CP0_TIMER_EN
      ip_next = {hwint[5] | timer_flag_q, hwint[4:0]};
`else
      ip_next = hwint;
`endif
   end

   // -----------------------------------------------------------------------
   // Request arbitration
   // -----------------------------------------------------------------------
   // EXL masks both sources, so a handler is never re-entered.
   assign irq     = ie_q & ~exl_q & (|(im_q & ip_next));
   assign exc     = exc_valid & ~exl_q;
   assign int_req = irq | exc;

   // A taken request squashes the MEM instruction, including its mtc0.
   assign wr_en  = we & ~int_req;
   assign wr_sr  = wr_en & (addr == AddrSr);
   assign wr_epc = wr_en & (addr == AddrEpc);

`ifdef CP0_TIMER_EN
   assign wr_count   = wr_en & (addr == AddrCount);
   assign wr_compare = wr_en & (addr == AddrCompare);
`endif

   // Delay-slot instructions restart at the branch; subtraction wraps mod 2^32.
   assign pc_target = bd ? (pc - 32'd4) : pc;

   // Bypass lets an mtc0 EPC followed directly by eret see the new value.
   assign epc_out = (we && (addr == AddrEpc)) ? {din[31:2], 2'b00} : epc_q;

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      ip_d       = ip_next;

      if (int_req) begin
         exl_d      = 1'b1;
         bd_d       = bd;
         // Interrupt outranks a concurrent exception and reports ExcCode 0.
         exc_code_d = irq ? 5'd0 : exc_code;
         epc_d      = {pc_target[31:2], 2'b00};
      end else begin
         if (wr_sr) begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
         end
         if (wr_epc) begin
            epc_d = {din[31:2], 2'b00};
         end
         // eret outranks an mtc0 that writes EXL in the same cycle.
         if (eret) begin
            exl_d = 1'b0;
         end
      end
   end

`ifdef CP0_TIMER_EN
   always_comb begin
      count_d      = wr_count ? din : (count_q + 32'd1);
      compare_d    = wr_compare ? din : compare_q;
      // Flag is sticky until software rewrites Compare.
      if (wr_compare) begin
         timer_flag_d = 1'b0;
      end else begin
         timer_flag_d = timer_flag_q | (count_d == compare_q);
      end
   end
`endif

   // -----------------------------------------------------------------------
   // State registers, synchronous active-low reset
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         im_q       <= 6'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= 6'd0;
         exc_code_q <= 5'd0;
         epc_q      <= 32'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

`ifdef CP0_TIMER_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q      <= 32'd0;
         compare_q    <= 32'd0;
         timer_flag_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         compare_q    <= compare_d;
         timer_flag_q <= timer_flag_d;
      end
   end
`endif

   // -----------------------------------------------------------------------
   // mfc0 read mux, pre-edge contents
   // -----------------------------------------------------------------------
   always_comb begin
      dout = 32'd0;
      case (addr)
         AddrSr:    dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
         AddrCause: dout = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
         AddrEpc:   dout = epc_q;
         AddrPrid:  dout = PRID;
`ifdef CP0_TIMER_EN
         AddrCount:   dout = count_q;
         AddrCompare: dout = compare_q;
`endif
         default:   dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl (default build, timer not enabled).
// A directed table walks the documented corner cases, then randomized
// traffic is compared against a word-level model of the CP0 registers.

module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h4255_4141;

   logic        clk;
   logic        reset;
   logic [4:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic [31:0] pc;
   logic        bd;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        eret;
   logic [5:0]  hwint;
   logic        int_req;
   logic [31:0] epc_out;

   int checks = 0;
   int errors = 0;

   cp0_exc_ctrl #(.PRID(PRID)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .we        (we),
      .din       (din),
      .dout      (dout),
      .pc        (pc),
      .bd        (bd),
      .exc_valid (exc_valid),
      .exc_code  (exc_code),
      .eret      (eret),
      .hwint     (hwint),
      .int_req   (int_req),
      .epc_out   (epc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      bit          rst_n;
      logic [4:0]  a;
      bit          w;
      logic [31:0] d;
      logic [31:0] p;
      bit          b;
      bit          ev;
      logic [4:0]  ec;
      bit          er;
      logic [5:0]  hw;
      bit          x_req;
      logic [31:0] x_dout;
      logic [31:0] x_epc;
   } vec_t;

   vec_t vecs[$];

   // Word-level model of SR, Cause, EPC
   logic [31:0] m_sr;
   logic [31:0] m_cause;
   logic [31:0] m_epc;

   task automatic add(input bit chk, input bit rst_n, input logic [4:0] a, input bit w,
                      input logic [31:0] d, input logic [31:0] p, input bit b, input bit ev,
                      input logic [4:0] ec, input bit er, input logic [5:0] hw,
                      input bit x_req, input logic [31:0] x_dout, input logic [31:0] x_epc);
      vec_t v;
      v.chk = chk; v.rst_n = rst_n; v.a = a; v.w = w; v.d = d; v.p = p; v.b = b;
      v.ev = ev; v.ec = ec; v.er = er; v.hw = hw;
      v.x_req = x_req; v.x_dout = x_dout; v.x_epc = x_epc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit m_irq();
      logic [5:0] im;
      im = m_sr[15:10];
      return m_sr[0] && !m_sr[1] && ((im & hwint) != 6'd0);
   endfunction

   function automatic bit m_req();
      return m_irq() || (exc_valid && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_dout();
      case (addr)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_epc_out();
      if (we && addr == 5'd14) return din & 32'hFFFF_FFFC;
      return m_epc;
   endfunction

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      bit req;
      bit irq;
      logic [31:0] tgt;
      if (!reset) begin
         m_sr = 32'd0;
         m_cause = 32'd0;
         m_epc = 32'd0;
      end else begin
         req = m_req();
         irq = m_irq();
         m_cause[15:10] = hwint;
         if (req) begin
            m_sr[1] = 1'b1;
            m_cause[31] = bd;
            m_cause[6:2] = irq ? 5'd0 : exc_code;
            tgt = bd ? pc - 32'd4 : pc;
            m_epc = tgt & 32'hFFFF_FFFC;
         end else begin
            if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
            if (we && addr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
            if (eret) m_sr[1] = 1'b0;
         end
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst_n; addr = v.a; we = v.w; din = v.d; pc = v.p; bd = v.b;
      exc_valid = v.ev; exc_code = v.ec; eret = v.er; hwint = v.hw;
   endtask

   initial begin
      int n;
      logic [31:0] r;
      logic [4:0] addr_pool[6];
      addr_pool[0] = 5'd9;  addr_pool[1] = 5'd12; addr_pool[2] = 5'd13;
      addr_pool[3] = 5'd14; addr_pool[4] = 5'd15; addr_pool[5] = 5'd3;

      reset = 1'b0; addr = 5'd0; we = 1'b0; din = 32'd0; pc = 32'd0; bd = 1'b0;
      exc_valid = 1'b0; exc_code = 5'd0; eret = 1'b0; hwint = 6'd0;
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;

      //  chk rst addr we din          pc           bd ev code er hw      req dout         epc_out
      add(0, 0, 15, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);
      add(1, 1, 14, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);
      add(1, 1, 15, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, PRID,         32'h0);
      // mtc0 SR = IM[10] | IE with line 0 high: request only after the write lands
      add(1, 1, 12, 1, 32'h401,      32'h0,       0, 0, 0,  0, 6'h01,  0, 32'h0,        32'h0);
      add(1, 1, 12, 0, 32'h0,        32'h1000,    0, 0, 0,  0, 6'h01,  1, 32'h401,      32'h0);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h01,  0, 32'h400,      32'h1000);
      // EXL masks an exception too
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 1, 12, 0, 6'h01,  0, 32'h403,      32'h1000);
      add(1, 1, 14, 0, 32'h0,        32'h0,       0, 0, 0,  1, 6'h00,  0, 32'h1000,     32'h1000);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h401,      32'h1000);
      add(1, 1, 12, 1, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h401,      32'h1000);
      // Overflow in a delay slot
      add(1, 1, 13, 0, 32'h0,        32'h3008,    1, 1, 12, 0, 6'h00,  1, 32'h0,        32'h1000);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h8000_0030, 32'h3004);
      // mtc0 EPC + eret together: bypass, then EXL clears
      add(1, 1, 14, 1, 32'h3011,     32'h0,       0, 0, 0,  1, 6'h00,  0, 32'h3004,     32'h3010);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h3010);
      add(1, 1, 12, 1, 32'h801,      32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h3010);
      // Interrupt + exception + mtc0 SR all at once
      add(1, 1, 12, 1, 32'hFC01,     32'h2000,    0, 1, 10, 0, 6'h02,  1, 32'h801,      32'h3010);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h800,      32'h2000);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h803,      32'h2000);
      add(1, 1, 14, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h2000,     32'h2000);
      // Unmapped/read-only addresses
      add(1, 1, 9,  1, 32'hFFFF,     32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h2000);
      add(1, 1, 9,  0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h2000);
      add(1, 1, 13, 1, 32'hFFFF_FFFF, 32'h0,      0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h2000);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h2000);
      // pc - 4 wraps
      add(1, 1, 0,  0, 32'h0,        32'h0,       0, 0, 0,  1, 6'h00,  0, 32'h0,        32'h2000);
      add(1, 1, 14, 0, 32'h0,        32'h0,       1, 1, 4,  0, 6'h00,  1, 32'h2000,     32'h2000);
      add(1, 1, 14, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      add(1, 1, 13, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h8000_0010, 32'hFFFF_FFFC);
      // eret alongside a request is ignored
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  1, 6'h00,  0, 32'h803,      32'hFFFF_FFFC);
      add(1, 1, 12, 0, 32'h0,        32'h40,      0, 1, 5,  1, 6'h00,  1, 32'h801,      32'hFFFF_FFFC);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h803,      32'h40);
      // Mid-run reset
      add(1, 0, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h803,      32'h40);
      add(1, 1, 12, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);
      add(1, 1, 14, 0, 32'h0,        32'h0,       0, 0, 0,  0, 6'h00,  0, 32'h0,        32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         if (vecs[i].chk) begin
            check($sformatf("vec%0d int_req", i), {31'd0, int_req}, {31'd0, vecs[i].x_req});
            check($sformatf("vec%0d dout", i), dout, vecs[i].x_dout);
            check($sformatf("vec%0d epc_out", i), epc_out, vecs[i].x_epc);
         end
         model_edge();
      end

      // Randomized traffic against the model
      n = 400;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 49) != 0);
         addr = addr_pool[$urandom_range(0, 5)];
         we = ($urandom_range(0, 2) == 0);
         r = $urandom;
         din = r;
         if ($urandom_range(0, 1) == 0) din = r & 32'h0000_FC03;
         r = $urandom;
         pc = {r[31:2], 2'b00};
         bd = r[0];
         exc_valid = ($urandom_range(0, 5) == 0);
         r = $urandom;
         exc_code = r[4:0];
         eret = ($urandom_range(0, 5) == 0);
         r = $urandom;
         hwint = ($urandom_range(0, 3) == 0) ? r[5:0] : 6'd0;
         #1;
         check("rand int_req", {31'd0, int_req}, {31'd0, m_req()});
         check("rand dout", dout, m_dout());
         check("rand epc_out", epc_out, m_epc_out());
         model_edge();
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
